jtframe_status_sync: RTL and testbench

- Frame-synchronous shadow register for the OSD status word.
- The OSD/host writes status bytes in bursts. The block assembles them in a shadow copy and commits the whole word atomically during vertical blank.
- Downstream DIP/video decode (rotation, scanlines, aspect, FX level) therefore never changes mid-frame or from a partial update.
- Sits between the OSD/HPS status interface and the DIP decode logic.

---
 rtl/jtframe_status_sync.sv | 147 ++++++++++++++
 tb/tb_jtframe_status_sync.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_status_sync.sv
// jtframe_status_sync
//   Frame-synchronous shadow register for the OSD status word. Status bytes
//   arrive in bursts from the OSD/host side and are collected in a shadow
//   copy. The whole word is committed to status_out atomically during
//   vertical blank. DIP/video decode therefore never sees a mid-frame change
//   or a partially written update.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   wr_en       byte write strobe, one byte per cycle
//   wr_addr     byte index; byte n maps to status bits [8n+7:8n]
//   wr_data     byte value
//   wr_last     final byte of a burst (qualified by wr_en)
//   vb          vertical blank, active-high, synchronous to clk
//   status_out  committed status word
//   pending     high while an update is collected but not yet committed
//   commit      one-cycle pulse aligned with a new status_out value
//   abort       one-cycle pulse when an open burst times out
module jtframe_status_sync #(
    parameter int                 BYTES  = 8,
    parameter int                 AW     = 3,
    parameter int                 TOW    = 16,
    parameter logic [8*BYTES-1:0] RSTVAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               wr_last,
    input  logic               vb,
    output logic [8*BYTES-1:0] status_out,
    output logic               pending,
    output logic               commit,
    output logic               abort
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_VB,
        COMMIT
    } state_t;

    state_t             state, state_nxt;
    logic [TOW-1:0]     cnt, cnt_nxt;
    logic [8*BYTES-1:0] shadow, shadow_wr;
    logic               do_abort, do_commit;

    // Shadow with the current byte write applied. Addresses at or above
    // BYTES match no lane and leave the shadow untouched.
    always_comb begin
        shadow_wr = shadow;
        if (wr_en) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wr_addr == AW'(i)) begin
                    shadow_wr[8*i +: 8] = wr_data;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_abort  = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (wr_en) begin
                    state_nxt = wr_last ? WAIT_VB : COLLECT;
                end
            end
            COLLECT: begin
                if (wr_en) begin
                    cnt_nxt = '0;
                    if (wr_last) begin
                        state_nxt = WAIT_VB;
                    end
                end else begin
                    // Abort on the idle cycle that brings the counter to
                    // all-ones; the register itself never holds all-ones.
                    cnt_nxt = cnt + TOW'(1);
                    if (cnt_nxt == '1) begin
                        do_abort  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_VB: begin
                cnt_nxt = '0;
                // A new write takes priority over vb so an extended update
                // is never committed half-way.
                if (wr_en) begin
                    if (!wr_last) begin
                        state_nxt = COLLECT;
                    end
                end else if (vb) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                do_commit = 1'b1;
                cnt_nxt   = '0;
                if (wr_en) begin
                    state_nxt = wr_last ? WAIT_VB : COLLECT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= RSTVAL;
            status_out <= RSTVAL;
            commit     <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            // Abort only happens on a cycle without wr_en, so restoring the
            // shadow never drops a same-cycle write.
            shadow <= do_abort ? status_out : shadow_wr;
            // The commit takes the shadow as it was before any write landing
            // on this same edge.
            if (do_commit) begin
                status_out <= shadow;
            end
            commit <= do_commit;
            abort  <= do_abort;
        end
    end

    assign pending = (state != IDLE);

endmodule

// File: tb/tb_jtframe_status_sync.sv
module tb_jtframe_status_sync;

    localparam int          BYTES = 6;
    localparam int          AW    = 3;
    localparam int          TOW   = 4;
    localparam int          W     = 8*BYTES;
    localparam logic [W-1:0] RSTV = 48'h4567_89AB_CDEF;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]   wr_data;
    logic         wr_last;
    logic         vb;
    logic [W-1:0] status_out;
    logic         pending;
    logic         commit;
    logic         abort;

    jtframe_status_sync #(
        .BYTES  (BYTES),
        .AW     (AW),
        .TOW    (TOW),
        .RSTVAL (RSTV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .vb         (vb),
        .status_out (status_out),
        .pending    (pending),
        .commit     (commit),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference: the word as the host has written it, and the word that
    // should currently be visible downstream.
    logic [W-1:0] m_sh;
    logic [W-1:0] m_st;
    int n_commit    = 0;
    int n_abort     = 0;
    int exp_commits = 0;
    int exp_aborts  = 0;

    always @(negedge clk) begin
        if (commit === 1'b1) n_commit++;
        if (abort === 1'b1)  n_abort++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int addr, input logic [7:0] d, input logic last);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = d;
        wr_last = last;
        if (addr < BYTES) m_sh[8*addr +: 8] = d;
        tick();
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] d;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0; vb = 1'b0;
        idle(2);
        rst = 1'b0;
        m_sh = RSTV;
        m_st = RSTV;
        chk("reset_status", 64'(status_out), 64'(RSTV));
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_commit", 64'(commit), 64'd0);
        chk("reset_abort", 64'(abort), 64'd0);

        // Burst held off by vb=0, then committed in the next blank.
        wr(0, 8'h5A, 1'b0);
        wr(5, 8'hC3, 1'b1);
        idle(100);
        chk("hold_status", 64'(status_out), 64'(m_st));
        chk("hold_pending", 64'(pending), 64'd1);
        vb = 1'b1;
        tick();
        chk("vb_first_commit", 64'(commit), 64'd0);
        chk("vb_first_status", 64'(status_out), 64'(m_st));
        tick();
        m_st = m_sh;
        exp_commits++;
        chk("vb_commit_status", 64'(status_out), 64'(m_st));
        chk("vb_commit_pulse", 64'(commit), 64'd1);
        chk("vb_commit_pending", 64'(pending), 64'd0);
        vb = 1'b0;
        tick();
        chk("vb_commit_single", 64'(commit), 64'd0);

        // Randomized bursts, including addresses past the last byte.
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 4);
            vb = 1'b0;
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom);
                wr($urandom_range(0, 7), d, (j == n - 1));
            end
            idle($urandom_range(0, 10));
            chk("rnd_hold_status", 64'(status_out), 64'(m_st));
            chk("rnd_hold_pending", 64'(pending), 64'd1);
            vb = 1'b1;
            idle(2);
            m_st = m_sh;
            exp_commits++;
            chk("rnd_commit_status", 64'(status_out), 64'(m_st));
            chk("rnd_commit_pulse", 64'(commit), 64'd1);
            vb = 1'b0;
            tick();
            chk("rnd_idle_pending", 64'(pending), 64'd0);
        end

        // Reopened burst from WAIT_VB times out even though vb is high.
        vb = 1'b0;
        wr(2, 8'hAA, 1'b1);
        wr(1, 8'h11, 1'b0);
        vb = 1'b1;
        idle(2**TOW - 2);
        chk("to_before_abort", 64'(abort), 64'd0);
        chk("to_before_pending", 64'(pending), 64'd1);
        idle(1);
        m_sh = m_st;
        exp_aborts++;
        chk("to_abort_pulse", 64'(abort), 64'd1);
        chk("to_abort_pending", 64'(pending), 64'd0);
        chk("to_abort_status", 64'(status_out), 64'(m_st));
        d = 8'($urandom);
        wr(3, d, 1'b1);
        chk("to_abort_single", 64'(abort), 64'd0);
        idle(2);
        m_st = m_sh;
        exp_commits++;
        chk("to_restore_status", 64'(status_out), 64'(m_st));
        chk("to_restore_commit", 64'(commit), 64'd1);

        // Out-of-range address with vb already high: commits, no data change.
        wr(7, 8'($urandom), 1'b1);
        idle(2);
        exp_commits++;
        chk("oob_commit", 64'(commit), 64'd1);
        chk("oob_status", 64'(status_out), 64'(m_st));
        vb = 1'b0;
        tick();

        // Write landing on the COMMIT cycle goes into the next commit.
        d = 8'($urandom);
        wr(0, d, 1'b1);
        vb = 1'b1;
        tick();
        chk("cc_in_commit", 64'(commit), 64'd0);
        m_st = m_sh;
        wr(0, 8'hFF, 1'b1);
        exp_commits++;
        chk("cc_first_status", 64'(status_out), 64'(m_st));
        chk("cc_first_pulse", 64'(commit), 64'd1);
        tick();
        chk("cc_gap", 64'(commit), 64'd0);
        tick();
        m_st = m_sh;
        exp_commits++;
        chk("cc_second_status", 64'(status_out), 64'(m_st));
        chk("cc_second_pulse", 64'(commit), 64'd1);
        vb = 1'b0;
        tick();

        // Reset in the middle of a burst discards it.
        wr(3, 8'($urandom), 1'b0);
        chk("mr_pending", 64'(pending), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_sh = RSTV;
        m_st = RSTV;
        chk("mr_status", 64'(status_out), 64'(RSTV));
        chk("mr_pending_clr", 64'(pending), 64'd0);
        d = 8'($urandom);
        wr(5, d, 1'b1);
        vb = 1'b1;
        idle(2);
        m_st = m_sh;
        exp_commits++;
        chk("mr_commit_status", 64'(status_out), 64'(m_st));
        vb = 1'b0;
        idle(2);

        chk("commit_count", 64'(n_commit), 64'(exp_commits));
        chk("abort_count", 64'(n_abort), 64'(exp_aborts));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
